// File: rtl/sdram_rect_responder_pkg.sv
//------------------------------------------------------------------------------
// sdram_rect_responder_pkg : state encoding and frame-buffer constants
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
package sdram_rect_responder_pkg;
  localparam int BYTES_PER_PIXEL = 4;
  localparam int PIXEL_SHIFT     = 2;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam logic [31:0] FRAME_BYTES = 32'(DEF_SCREEN_W * DEF_SCREEN_H * BYTES_PER_PIXEL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_EVAL    = 3'd4,
    ST_WR_REQ  = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic [31:0] pixel_byte_offset(input logic [31:0] x,
                                                    input logic [31:0] y,
                                                    input logic [31:0] pitch);
    return (y * pitch + x) << PIXEL_SHIFT;
  endfunction
endpackage
`default_nettype wire

// File: rtl/sdram_rect_responder_addr_gen.sv
//------------------------------------------------------------------------------
// rect_addr_gen : registered pixel x/y -> frame-buffer byte address
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
module rect_addr_gen
  import sdram_rect_responder_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = DEF_SCREEN_W
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [31:0]        base,
  output logic [31:0]        address
);
  localparam logic [31:0] c_pitch = 32'(SCREEN_W);

  always_ff @(posedge sys_clk) begin
    if (reset)
      address <= '0;
    else if (load)
      address <= base + pixel_byte_offset(32'(x), 32'(y), c_pitch);
  end
endmodule
`default_nettype wire

// File: rtl/sdram_rect_responder.sv
//------------------------------------------------------------------------------
// sdram_rect_responder : walks a rectangle, reads each pixel, writes back drawer colour
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
module sdram_rect_responder
  import sdram_rect_responder_pkg::*;
#(
  parameter int COORD_W    = 16,
  parameter int COLOUR_W   = 32,
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter bit SKIP_EQUAL = 1'b1
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  x_start,
  input  logic [COORD_W-1:0]  y_start,
  input  logic [COORD_W-1:0]  x_length,
  input  logic [COORD_W-1:0]  y_length,
  input  logic [31:0]         base_addr_offset,
  input  logic [COLOUR_W-1:0] new_color,
  output logic [COORD_W-1:0]  current_x,
  output logic [COORD_W-1:0]  current_y,
  output logic [COLOUR_W-1:0] old_color,
  output logic                done,
  output logic                busy,
  output logic [31:0]         avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [COLOUR_W-1:0] avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic [COLOUR_W-1:0] avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);
  localparam logic [COORD_W:0] c_screen_w = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] c_screen_h = (COORD_W+1)'(SCREEN_H);

  state_t                r_state, w_next;
  logic [COORD_W-1:0]    r_x0;
  logic [COORD_W:0]      r_x, r_y, r_x_end, r_y_end;
  logic [31:0]           r_base;
  logic [COLOUR_W-1:0]   r_old, r_wdata;
  logic                  r_busy, r_done;
  logic                  w_addr_load, w_off_screen, w_x_last, w_y_last;

  // Coordinates carry one extra bit so a walk past 2^COORD_W-1 stays off-screen instead of wrapping
  assign w_off_screen = (r_x >= c_screen_w) || (r_y >= c_screen_h);
  assign w_x_last     = (r_x == r_x_end);
  assign w_y_last     = (r_y == r_y_end);

  rect_addr_gen #(
    .COORD_W  (COORD_W),
    .SCREEN_W (SCREEN_W)
  ) u_addr_gen (
    .sys_clk (sys_clk),
    .reset   (reset),
    .load    (w_addr_load),
    .x       (r_x[COORD_W-1:0]),
    .y       (r_y[COORD_W-1:0]),
    .base    (r_base),
    .address (avm_address)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x0    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_base  <= '0;
      r_old   <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: if (start) begin
          r_x0    <= x_start;
          r_x     <= {1'b0, x_start};
          r_y     <= {1'b0, y_start};
          r_x_end <= {1'b0, x_start} + {1'b0, x_length} - 1'b1;
          r_y_end <= {1'b0, y_start} + {1'b0, y_length} - 1'b1;
          r_base  <= base_addr_offset;
          r_busy  <= 1'b1;
        end
        ST_RD_WAIT: if (avm_readdatavalid) r_old <= avm_readdata;
        ST_EVAL:    r_wdata <= new_color;
        ST_NEXT: begin
          if (w_x_last) begin
            r_x <= {1'b0, r_x0};
            if (!w_y_last) r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        ST_DONE:    r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_addr_load = 1'b0;
    avm_read    = 1'b0;
    avm_write   = 1'b0;
    case (r_state)
      ST_IDLE: if (start)
        w_next = (x_length == '0 || y_length == '0) ? ST_DONE : ST_CHECK;
      ST_CHECK: begin
        w_addr_load = !w_off_screen;
        w_next      = w_off_screen ? ST_NEXT : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) w_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (avm_readdatavalid) w_next = ST_EVAL;
      ST_EVAL:
        w_next = (SKIP_EQUAL && new_color == r_old) ? ST_NEXT : ST_WR_REQ;
      ST_WR_REQ: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) w_next = ST_NEXT;
      end
      ST_NEXT: w_next = (w_x_last && w_y_last) ? ST_DONE : ST_CHECK;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign current_x      = r_x[COORD_W-1:0];
  assign current_y      = r_y[COORD_W-1:0];
  assign old_color      = r_old;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = 4'hF;
  assign busy           = r_busy;
  assign done           = r_done;
endmodule
`default_nettype wire
